// File: rtl/rvb_clmul_arbiter.sv
// rvb_clmul_arbiter
// Shares one multi-cycle carry-less multiply unit among NREQ issue ports.
// One operation is in flight at a time. A request is granted round-robin in
// IDLE and its operands are captured. The unit is started in ISSUE and
// awaited in WAIT under a watchdog. The result is then held in RESP until the
// consumer takes it. Illegal op codes and watchdog expiry produce an error
// response with zero data.
module rvb_clmul_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_rs1,
  input  logic [32*NREQ-1:0]  req_rs2,
  input  logic [2*NREQ-1:0]   req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_id,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                unit_start,
  input  logic                unit_ready,
  output logic [1:0]          unit_op,
  output logic [31:0]         unit_rs1,
  output logic [31:0]         unit_rs2,
  input  logic                unit_done,
  input  logic [31:0]         unit_result
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;

  // Captured operation and response registers.
  logic [1:0]      last_q;
  logic [1:0]      id_q;
  logic            illegal_q;
  logic [1:0]      op_q;
  logic [31:0]     rs1_q;
  logic [31:0]     rs2_q;
  logic [31:0]     data_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;

  // Round-robin search results and the selected requester's operands.
  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [2:0]      cand;
  logic [31:0]     sel_rs1;
  logic [31:0]     sel_rs2;
  logic [1:0]      sel_op;

  // FSM strobes.
  logic            accept;
  logic            issue_fire;
  logic            done_fire;
  logic            timeout_fire;
  logic            illegal_fire;
  logic            cnt_expired;

  assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));

  // Round-robin search: first valid requester starting at last+1 (mod NREQ).
  // NOTE: every variable written in always_comb gets a default at the top so
  // no path leaves it unassigned; a missing default infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && (cand == 3'(i))) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
        end
      end
    end
  end

  // Operand mux for the requester that wins the search.
  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_rs1 = req_rs1[32*i +: 32];
        sel_rs2 = req_rs2[32*i +: 32];
        sel_op  = req_op[2*i +: 2];
      end
    end
  end

  // State register; reset is sampled on the clock edge and wins over any
  // in-flight operation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and combinational handshake outputs.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    issue_fire   = 1'b0;
    done_fire    = 1'b0;
    timeout_fire = 1'b0;
    illegal_fire = 1'b0;
    req_ready    = '0;
    unit_start   = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          accept = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (grant_idx == 2'(i));
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (illegal_q) begin
          illegal_fire = 1'b1;
          state_d      = S_RESP;
        end else begin
          unit_start = 1'b1;
          if (unit_ready) begin
            issue_fire = 1'b1;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (unit_done) begin
          done_fire = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_expired) begin
          timeout_fire = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operation capture, watchdog counter and response registers.
  // NOTE: every register here is reset because each one drives an output
  // (or the arbitration order) whose post-reset value must be defined.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q    <= 2'(NREQ - 1);
      id_q      <= '0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        last_q    <= grant_idx;
        id_q      <= grant_idx;
        rs1_q     <= sel_rs1;
        rs2_q     <= sel_rs2;
        illegal_q <= (sel_op == OP_ILLEGAL);
        // The unit never sees the illegal code; it is never started for it.
        op_q      <= (sel_op == OP_ILLEGAL) ? 2'b00 : sel_op;
      end
      if (issue_fire) begin
        cnt_q <= '0;
      end else if ((state_q == S_WAIT) && !unit_done && !cnt_expired) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // Late done pulses outside WAIT never reach here, so a held error
      // response keeps zero data.
      if (done_fire) begin
        data_q <= unit_result;
        err_q  <= 1'b0;
      end else if (timeout_fire || illegal_fire) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign unit_op  = op_q;
  assign unit_rs1 = rs1_q;
  assign unit_rs2 = rs2_q;

endmodule

// File: tb/tb_rvb_clmul_arbiter.sv
// Testbench for rvb_clmul_arbiter: directed vectors with hand-computed
// results, a behavioural clmul unit (latency 5) and a response scoreboard
// checked by an independent monitor.
module tb_rvb_clmul_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_rs1 = '0;
  logic [32*NREQ-1:0]  req_rs2 = '0;
  logic [2*NREQ-1:0]   req_op = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic                unit_start;
  logic                unit_ready = 1'b1;
  logic [1:0]          unit_op;
  logic [31:0]         unit_rs1;
  logic [31:0]         unit_rs2;
  logic                unit_done;
  logic [31:0]         unit_result;

  rvb_clmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .unit_start  (unit_start),
    .unit_ready  (unit_ready),
    .unit_op     (unit_op),
    .unit_rs1    (unit_rs1),
    .unit_rs2    (unit_rs2),
    .unit_done   (unit_done),
    .unit_result (unit_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- behavioural clmul unit ----------------
  logic        hang = 1'b0;
  logic        inj_done = 1'b0;
  logic [31:0] inj_result = '0;
  int          cd = 0;
  logic [31:0] mres = '0;

  function automatic logic [31:0] clmul_ref(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ (64'(a) << i);
    end
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      cd <= 0;
    end else if (unit_start && unit_ready && !hang) begin
      cd   <= LAT;
      mres <= clmul_ref(unit_op, unit_rs1, unit_rs2);
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
  end

  assign unit_done   = (cd == 1) || inj_done;
  assign unit_result = inj_done ? inj_result : ((cd == 1) ? mres : 32'h0);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_exp = 0;
  int   n_rsp = 0;
  int   rsp_rise_cyc = 0;
  int   start_rise_cyc = 0;
  int   start_cnt = 0;
  logic rsp_valid_d = 1'b0;
  logic unit_start_d = 1'b0;

  int   g_order[8];
  int   g_cyc[8];
  int   g_n = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] data, input logic err);
    rsp_t e;
    e.id   = 2'(id);
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
    n_exp++;
  endtask

  // Monitor: compares every accepted response against the scoreboard head,
  // and records handshake timing for the stimulus process.
  always @(negedge clock) begin
    if (!reset) begin
      rsp_valid_d  = 1'b0;
      unit_start_d = 1'b0;
    end else begin
      if (rsp_valid && !rsp_valid_d) rsp_rise_cyc = cyc;
      if (unit_start && !unit_start_d) start_rise_cyc = cyc;
      if (unit_start) start_cnt++;
      rsp_valid_d  = rsp_valid;
      unit_start_d = unit_start;
      if (req_ready != '0) check_eq("grant onehot", 32'($onehot(req_ready)), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("response with empty scoreboard", 32'(exp_q.size()), 32'd1);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_id",   32'(rsp_id),  32'(e.id));
          check_eq("rsp_data", rsp_data,     e.data);
          check_eq("rsp_err",  32'(rsp_err), 32'(e.err));
          n_rsp++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_rs1[32*r +: 32] = a;
    req_rs2[32*r +: 32] = b;
    req_op[2*r +: 2]    = op;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] exp_data,
                       input logic exp_err, output int t);
    t = -1;
    @(posedge clock); #1;
    set_req(r, a, b, op);
    req_valid[r] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (req_ready[r]) begin
        t = cyc;
        push_exp(r, exp_data, exp_err);
        break;
      end
    end
    if (t < 0) check_eq("grant wait expired", 32'd0, 32'd1);
    @(posedge clock); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp();
    int c;
    c = 0;
    while (n_rsp < n_exp && c < 300) begin
      @(posedge clock); #1;
      c++;
    end
    check_eq("responses received", 32'(n_rsp), 32'(n_exp));
  endtask

  task automatic contend(input int per_req);
    int cnt0;
    int cnt1;
    cnt0 = 0;
    cnt1 = 0;
    g_n  = 0;
    @(posedge clock); #1;
    req_valid = 2'b11;
    for (int c = 0; c < 400 && g_n < 2*per_req; c++) begin
      @(negedge clock);
      if (req_ready[0] && g_n < 8) begin g_order[g_n] = 0; g_cyc[g_n] = cyc; g_n++; cnt0++; end
      if (req_ready[1] && g_n < 8) begin g_order[g_n] = 1; g_cyc[g_n] = cyc; g_n++; cnt1++; end
      @(posedge clock); #1;
      if (cnt0 >= per_req) req_valid[0] = 1'b0;
      if (cnt1 >= per_req) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    check_eq("contention grant count", 32'(g_n), 32'(2*per_req));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " req_ready"},  32'(req_ready),  32'd0);
    check_eq({tag, " rsp_valid"},  32'(rsp_valid),  32'd0);
    check_eq({tag, " rsp_id"},     32'(rsp_id),     32'd0);
    check_eq({tag, " rsp_data"},   rsp_data,        32'd0);
    check_eq({tag, " rsp_err"},    32'(rsp_err),    32'd0);
    check_eq({tag, " unit_start"}, 32'(unit_start), 32'd0);
    check_eq({tag, " unit_op"},    32'(unit_op),    32'd0);
    check_eq({tag, " unit_rs1"},   unit_rs1,        32'd0);
    check_eq({tag, " unit_rs2"},   unit_rs2,        32'd0);
  endtask

  // Hard stop in case anything above fails to terminate.
  initial begin
    #100000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int tr;
    int s0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    // CLMUL 3 x 3 = 5 from requester 0; start at T+1, response at T+7.
    issue(0, 32'h0000_0003, 32'h0000_0003, 2'b00, 32'h0000_0005, 1'b0, t);
    wait_rsp();
    check_eq("clmul start latency", 32'(start_rise_cyc), 32'(t + 1));
    check_eq("clmul rsp latency",   32'(rsp_rise_cyc),   32'(t + 7));

    // CLMULH: x^31 * x^31 = x^62 -> high word bit 30.
    issue(1, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 1'b0, t);
    wait_rsp();
    // CLMULR: x^31 * x^1 = x^32 -> bits [62:31] gives bit 1.
    issue(0, 32'h8000_0000, 32'h0000_0002, 2'b10, 32'h0000_0002, 1'b0, t);
    wait_rsp();
    // CLMUL by x^8 is a left shift by 8.
    issue(1, 32'h1234_5678, 32'h0000_0100, 2'b00, 32'h3456_7800, 1'b0, t);
    wait_rsp();

    // Fairness: last grant was 1, so order is 0,1,0,1; 5x3=0xF, 7x7=0x15.
    set_req(0, 32'h0000_0005, 32'h0000_0003, 2'b00);
    set_req(1, 32'h0000_0007, 32'h0000_0007, 2'b00);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 32'h0000_000F, 1'b0);
      else            push_exp(1, 32'h0000_0015, 1'b0);
    end
    contend(2);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("fair order %0d", k), 32'(g_order[k]), 32'(k % 2));
    end
    check_eq("back-to-back spacing", 32'(g_cyc[1] - g_cyc[0]), 32'(LAT + 3));
    wait_rsp();

    // Backpressure: response held 10 cycles, pending requester 1 waits.
    rsp_ready = 1'b0;
    issue(0, 32'h0000_000F, 32'h0000_0011, 2'b00, 32'h0000_00FF, 1'b0, t);
    set_req(1, 32'h0000_0002, 32'h0000_0002, 2'b00);
    req_valid[1] = 1'b1;
    tr = -1;
    for (int c = 0; c < 50 && tr < 0; c++) begin
      @(negedge clock);
      if (rsp_valid) tr = cyc;
    end
    check_eq("bp rsp latency", 32'(tr), 32'(t + 7));
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check_eq("bp held data", rsp_data, 32'h0000_00FF);
      check_eq("bp held ctl", 32'({rsp_valid, rsp_err, rsp_id, req_ready}), 32'b1_0_00_00);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check_eq("no ready in handshake cycle", 32'(req_ready), 32'd0);
    @(negedge clock);
    check_eq("ready one cycle after handshake", 32'(req_ready), 32'b10);
    if (req_ready[1]) push_exp(1, 32'h0000_0004, 1'b0);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    wait_rsp();

    // Illegal op from requester 1: no unit start, error at T+2.
    s0 = start_cnt;
    issue(1, 32'h0000_AAAA, 32'h0000_5555, 2'b11, 32'h0, 1'b1, t);
    wait_rsp();
    check_eq("illegal no unit_start", 32'(start_cnt), 32'(s0));
    check_eq("illegal rsp latency", 32'(rsp_rise_cyc), 32'(t + 2));

    // Timeout: unit never completes; error after 16 WAIT cycles.
    hang = 1'b1;
    rsp_ready = 1'b0;
    issue(0, 32'h0000_0003, 32'h0000_0003, 2'b00, 32'h0, 1'b1, t);
    tr = -1;
    for (int c = 0; c < 60 && tr < 0; c++) begin
      @(negedge clock);
      if (rsp_valid) tr = cyc;
    end
    check_eq("timeout rsp latency", 32'(tr), 32'(t + 2 + TIMEOUT));
    @(posedge clock); #1;
    inj_result = 32'hDEAD_BEEF;
    inj_done = 1'b1;
    @(posedge clock); #1;
    inj_done = 1'b0;
    @(negedge clock);
    check_eq("late done data", rsp_data, 32'h0);
    check_eq("late done ctl", 32'({rsp_valid, rsp_err}), 32'b11);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_rsp();
    hang = 1'b0;

    // Reset mid-WAIT: in-flight op from requester 0 is discarded.
    issue(0, 32'h0000_0011, 32'h0000_0003, 2'b01, 32'h0, 1'b0, t);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_exp = n_exp - exp_q.size();
    exp_q.delete();
    @(negedge clock);
    check_reset_outputs("mid-wait reset");

    // After reset requester 0 wins contention again; 3x5=0xF, 9x3=0x1B.
    set_req(0, 32'h0000_0003, 32'h0000_0005, 2'b00);
    set_req(1, 32'h0000_0009, 32'h0000_0003, 2'b00);
    push_exp(0, 32'h0000_000F, 1'b0);
    push_exp(1, 32'h0000_001B, 1'b0);
    contend(1);
    check_eq("post-reset first grant",  32'(g_order[0]), 32'd0);
    check_eq("post-reset second grant", 32'(g_order[1]), 32'd1);
    wait_rsp();

    repeat (3) @(posedge clock);
    #1;
    check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
